channel_fifo: RTL and testbench
===============================

CHANNEL_FIFO -- requirements
Module: channel_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits.
REQ-002 Parameter DEPTH, default 4: number of storage entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_data  input  WIDTH  write data from the producer.
REQ-006 write_valid  input  1  producer push request.
REQ-007 read_valid  input  1  consumer pop request.
REQ-008 out_data  output  WIDTH  last popped word (registered).
REQ-009 write_ready  output  1  high when the FIFO is not full.
REQ-010 read_ready  output  1  high when the FIFO is not empty.
REQ-011 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH words, with a write pointer, a read pointer and an occupancy counter.
REQ-013 write_ready SHALL equal (count != DEPTH); it is combinational from registered state only.
REQ-014 read_ready SHALL equal (count != 0); it is combinational from registered state only.
REQ-015 A push is accepted on a rising edge when write_valid && write_ready: mem[wptr] <= in_data, and wptr advances by 1 modulo DEPTH.
REQ-016 A pop is accepted on a rising edge when read_valid && read_ready: out_data <= mem[rptr], and rptr advances by 1 modulo DEPTH.
REQ-017 Pop latency SHALL be one cycle: the popped word is visible on out_data in the cycle after the pop edge.
REQ-018 out_data SHALL hold its value until the next accepted pop; it does not follow the head entry.
REQ-019 Requests made while not ready SHALL be ignored, with no state change and no error flag.
REQ-020 Simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 When full, a push SHALL be refused even if a pop is accepted on the same edge; write_ready reflects only the pre-edge count.
REQ-022 When empty, a pop SHALL be refused even if a push is accepted on the same edge; there is no fall-through.
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; word order is strict FIFO across the wrap.
REQ-024 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.

Reset
REQ-025 While rst=1 at a rising edge: wptr=0, rptr=0, count=0, out_data=0.
REQ-026 Consequently, in the cycle after the reset edge: write_ready=1 and read_ready=0.
REQ-027 Storage contents SHALL NOT be cleared; they are unobservable after reset.
REQ-028 Reset mid-operation SHALL discard all queued words and any push or pop presented on the same edge, with reset taking priority.

Structure
REQ-029 The default WIDTH/DEPTH constants and the pointer-width function SHALL live in the shared channel package for reuse by producers and reducers.
REQ-030 One sub-module, channel_fifo_mem, SHALL hold the storage:
- DEPTH x WIDTH array;
- one synchronous write port;
- one asynchronous read port.
REQ-031 Control (pointers, count, out_data register) SHALL stay in channel_fifo; no other sub-modules.

Verification
REQ-032 Reset, then push 5,6,7,8 on consecutive cycles -> count=4, write_ready=0, read_ready=1.
REQ-033 From the full state, pop four times -> out_data reads 5,6,7,8, each one cycle after its pop edge; count=0, read_ready=0.
REQ-034 Push a fifth word 9 while full with no pop -> ignored; a later drain returns only 5,6,7,8.
REQ-035 With count=2 (words 1,2), push 3 and pop simultaneously -> out_data=1, count=2; the next two pops return 2,3.
REQ-036 Run 10 push/pop pairs with values 0..9 through DEPTH=4 -> FIFO order preserved across pointer wrap, no loss.
REQ-037 Assert rst with count=3 while write_valid=1 -> next cycle count=0, out_data=0, read_ready=0; a subsequent push of 0xAB followed by a pop returns 0xAB.

Source files
------------

// File: rtl/channel_fifo_pkg.sv
// Shared channel definitions: default FIFO geometry and pointer sizing used by
// producers, reducers and the channel FIFO itself.
package channel_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // Bits needed to address DEPTH entries; never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// Channel FIFO storage: DEPTH x WIDTH array, one synchronous write port and
// one asynchronous read port. Contents are never reset.
module channel_fifo_mem
    import channel_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/channel_fifo.sv
// Single-clock channel FIFO: circular buffer with registered pop data, no
// fall-through, and ready flags derived only from the registered occupancy.
module channel_fifo
    import channel_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      write_valid,
    input  logic                      read_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic                      write_ready,
    output logic                      read_ready,
    output logic [ptr_width(DEPTH):0] count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [WIDTH-1:0] rd_data;
    logic             push;
    logic             pop;

    // Readiness looks only at the pre-edge count, so a full FIFO refuses a
    // push even when a pop lands on the same edge (and vice versa when empty).
    assign write_ready = (count != CNT_W'(DEPTH));
    assign read_ready  = (count != '0);
    assign push        = write_valid && write_ready;
    assign pop         = read_valid && read_ready;

    channel_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // DEPTH is a power of two, so pointers wrap naturally at their width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr     <= rptr + PTR_W'(1);
                out_data <= rd_data;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_fifo.sv
// Directed self-checking bench for channel_fifo (WIDTH=32, DEPTH=4).
module tb_channel_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        write_valid;
    logic        read_valid;
    logic [31:0] out_data;
    logic        write_ready;
    logic        read_ready;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    channel_fifo #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .write_valid (write_valid),
        .read_valid  (read_valid),
        .out_data    (out_data),
        .write_ready (write_ready),
        .read_ready  (read_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] v);
        write_valid = 1'b1;
        in_data     = v;
        cycle();
        write_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp_v);
        read_valid = 1'b1;
        cycle();
        read_valid = 1'b0;
        chk(tag, out_data, exp_v);
    endtask

    initial begin
        rst         = 1'b1;
        in_data     = '0;
        write_valid = 1'b0;
        read_valid  = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wready", 32'(write_ready), 32'd1);
        chk("rst_rready", 32'(read_ready), 32'd0);
        chk("rst_out", out_data, 32'd0);

        // Fill with 5,6,7,8 on consecutive cycles
        write_valid = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            in_data = 32'(i);
            cycle();
        end
        write_valid = 1'b0;
        chk("full_count", 32'(count), 32'd4);
        chk("full_wready", 32'(write_ready), 32'd0);
        chk("full_rready", 32'(read_ready), 32'd1);

        // Push 9 while full: ignored
        push(32'd9);
        chk("ovf_count", 32'(count), 32'd4);

        // Drain back-to-back
        read_valid = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            cycle();
            chk("drain_out", out_data, 32'(i));
        end
        read_valid = 1'b0;
        chk("empty_count", 32'(count), 32'd0);
        chk("empty_rready", 32'(read_ready), 32'd0);
        chk("empty_wready", 32'(write_ready), 32'd1);

        // Pop while empty: ignored, out_data holds
        read_valid = 1'b1;
        cycle();
        read_valid = 1'b0;
        chk("udf_out", out_data, 32'd8);
        chk("udf_count", 32'(count), 32'd0);

        // Push and pop on empty: no fall-through
        write_valid = 1'b1;
        read_valid  = 1'b1;
        in_data     = 32'd1;
        cycle();
        write_valid = 1'b0;
        read_valid  = 1'b0;
        chk("nofall_out", out_data, 32'd8);
        chk("nofall_count", 32'(count), 32'd1);

        // count=2 (1,2), then simultaneous push 3 / pop
        push(32'd2);
        write_valid = 1'b1;
        read_valid  = 1'b1;
        in_data     = 32'd3;
        cycle();
        write_valid = 1'b0;
        read_valid  = 1'b0;
        chk("simul_out", out_data, 32'd1);
        chk("simul_count", 32'(count), 32'd2);
        pop_chk("simul_pop2", 32'd2);
        pop_chk("simul_pop3", 32'd3);
        chk("simul_end_count", 32'(count), 32'd0);

        // Full with push+pop on the same edge: push refused
        for (int i = 10; i <= 13; i++) push(32'(i));
        write_valid = 1'b1;
        read_valid  = 1'b1;
        in_data     = 32'd14;
        cycle();
        write_valid = 1'b0;
        read_valid  = 1'b0;
        chk("fullsim_out", out_data, 32'd10);
        chk("fullsim_count", 32'(count), 32'd3);
        pop_chk("fullsim_pop11", 32'd11);
        pop_chk("fullsim_pop12", 32'd12);
        pop_chk("fullsim_pop13", 32'd13);
        chk("fullsim_end_count", 32'(count), 32'd0);

        // Ten push/pop pairs across pointer wrap
        for (int i = 0; i < 10; i++) begin
            push(32'(i));
            pop_chk("wrap_out", 32'(i));
        end
        chk("wrap_count", 32'(count), 32'd0);

        // Reset with count=3 while push and pop are presented
        push(32'h21);
        push(32'h22);
        push(32'h23);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst         = 1'b1;
        write_valid = 1'b1;
        read_valid  = 1'b1;
        in_data     = 32'h55;
        cycle();
        rst         = 1'b0;
        write_valid = 1'b0;
        read_valid  = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_out", out_data, 32'd0);
        chk("midrst_rready", 32'(read_ready), 32'd0);
        chk("midrst_wready", 32'(write_ready), 32'd1);
        push(32'hAB);
        chk("post_rst_count", 32'(count), 32'd1);
        pop_chk("post_rst_out", 32'hAB);

        // out_data holds through idle cycles
        cycle();
        cycle();
        chk("hold_out", out_data, 32'hAB);
        chk("final_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
